// File: rtl/trig_delay_pulse_gen.sv
// Programmable trigger delay line and pulse shaper.
// Define TRIG_DROP_CNT_EN to build the saturating rejected-trigger counter.
`timescale 1ns/1ps

module trig_delay_pulse_gen #(
  parameter int DELAY_W = 3,
  parameter int DUR_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [DUR_W-1:0]   duration_i,
  output logic               trig_dly_o,
  output logic               pulse_o,
  output logic               busy_o,
  output logic               dropped_o,
  output logic [7:0]         drop_cnt_o
);

  localparam int DEPTH = 2 ** DELAY_W;
  localparam int CNT_W = (DUR_W > DELAY_W) ? DUR_W : DELAY_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0] n_q, n_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             trig_q;
  logic             rise;
  logic [DEPTH-1:1] sr_q;
  logic [DEPTH-1:0] taps;
  logic [CNT_W-1:0] d_m1;
  logic [CNT_W-1:0] n_m1;

  // Tap k of the line is trig_i delayed by k cycles; tap 0 is live.
  assign taps       = {sr_q, trig_i};
  assign trig_dly_o = taps[delay_i];
  assign rise       = trig_i & ~trig_q;

  // A zero delay still costs one registered cycle of latency.
  assign d_m1 = (delay_i == '0) ? '0
              : CNT_W'(delay_i) - CNT_W'(1);
  assign n_m1 = CNT_W'(n_q) - CNT_W'(1);

  // Delay line shift and rise-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
      sr_q   <= '0;
    end else begin
      trig_q <= trig_i;
      sr_q   <= taps[DEPTH-2:0];
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    drop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise && (duration_i != '0)) begin
          state_d = S_WAIT;
          cnt_d   = d_m1;
          n_d     = duration_i;
        end
      end
      S_WAIT: begin
        drop_d = rise;
        if (cnt_q == '0) begin
          state_d = S_ACTIVE;
          cnt_d   = n_m1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACTIVE: begin
        drop_d = rise;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    pulse_d = (state_d == S_ACTIVE);
    busy_d  = (state_d != S_IDLE);
  end

  // State register with registered pulse/busy/drop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign busy_o    = busy_q;
  assign dropped_o = drop_q;

`ifdef TRIG_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of rejected rises; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'h00;
    end else if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 8'h00;
`endif

endmodule
